// File: rtl/axis_oversample_vote.sv
// axis_oversample_vote: majority-vote decimator for an oversampled AXI-Stream.
// Each channel's OVS_FACTOR samples are popcounted and compared against THRESHOLD to give one symbol.
// tlast is voted the same way. A symbol is flagged low-confidence (tuser) when any channel's
// popcount falls strictly between OVS_FACTOR-THRESHOLD and THRESHOLD.
// Latency: the final sample is accepted at edge t; m_axis_tvalid is high in the cycle after t
//          when the output FIFO was empty.
// Backpressure: s_axis_tready = !fifo_full && !i_rst. The head word is held while m_axis_tready is low.
//
// Ports:
//   i_clk, i_rst             clock; asynchronous active-high reset
//   s_axis_t{data,valid,last,ready}
//                            oversampled chip stream (DATA_W channels)
//   m_axis_t{data,valid,last,user,ready}
//                            decided symbols; tuser = low-confidence flag
//   i_resync                 synchronous pulse that realigns the symbol phase to 0
//   o_sym_phase              index of the next sample within the current symbol

// Small synchronous FIFO used to queue decided symbols.
// Pushes are ignored when the FIFO is full, and pops are ignored when it is empty.
// The head word reads as zero while the FIFO is empty.
module axis_oversample_vote_fifo #(
   parameter int W     = 3,
   parameter int DEPTH = 2
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_push,
   input  logic [W-1:0] i_push_dat,
   input  logic         i_pop,
   output logic [W-1:0] o_head_dat,
   output logic         o_empty,
   output logic         o_full
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [W-1:0]     r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;

   // The depth need not be a power of two, so the pointers wrap explicitly.
   function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == CNT_W'(DEPTH));
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= f_next(r_wr_ptr);
         if (w_pop)  r_rd_ptr <= f_next(r_rd_ptr);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset: the pointers and count alone decide what is visible.
   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
   end

   assign o_head_dat = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

module axis_oversample_vote #(
   parameter int OVS_FACTOR = 4,
   parameter int DATA_W     = 1,
   parameter int THRESHOLD  = 3,
   parameter int OUT_DEPTH  = 2
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic [DATA_W-1:0]             s_axis_tdata,
   input  logic                          s_axis_tvalid,
   input  logic                          s_axis_tlast,
   output logic                          s_axis_tready,
   output logic [DATA_W-1:0]             m_axis_tdata,
   output logic                          m_axis_tvalid,
   output logic                          m_axis_tlast,
   output logic                          m_axis_tuser,
   input  logic                          m_axis_tready,
   input  logic                          i_resync,
   output logic [$clog2(OVS_FACTOR)-1:0] o_sym_phase
);

   localparam int PHASE_W = $clog2(OVS_FACTOR);
   localparam int CNT_W   = $clog2(OVS_FACTOR + 1);
   localparam int WORD_W  = DATA_W + 2;

   logic [PHASE_W-1:0] r_phase;
   logic [CNT_W-1:0]   r_cnt [DATA_W];
   logic [CNT_W-1:0]   r_last_cnt;

   logic               w_accept;
   logic               w_final;
   logic               w_push;
   logic               w_pop;
   logic               w_fifo_empty;
   logic               w_fifo_full;
   logic [CNT_W-1:0]   w_fcnt [DATA_W];
   logic [CNT_W-1:0]   w_last_fcnt;
   logic [DATA_W-1:0]  w_dec_dat;
   logic               w_dec_last;
   logic               w_low_conf;
   logic [WORD_W-1:0]  w_push_word;
   logic [WORD_W-1:0]  w_head_word;

   assign s_axis_tready = !w_fifo_full && !i_rst;
   assign w_accept      = s_axis_tvalid && s_axis_tready;
   assign w_final       = w_accept && (r_phase == PHASE_W'(OVS_FACTOR - 1));
   // A resync in the same cycle swallows the beat, even a final one.
   assign w_push        = w_final && !i_resync;

   // Final counts include the beat being accepted now. Before the final sample,
   // a count holds at most OVS_FACTOR-1, so adding one bit cannot overflow CNT_W.
   always_comb begin
      w_low_conf  = 1'b0;
      w_dec_dat   = '0;
      w_last_fcnt = r_last_cnt + CNT_W'(s_axis_tlast);
      w_dec_last  = (w_last_fcnt >= CNT_W'(THRESHOLD));
      for (int c = 0; c < DATA_W; c++) begin
         w_fcnt[c]    = r_cnt[c] + CNT_W'(s_axis_tdata[c]);
         w_dec_dat[c] = (w_fcnt[c] >= CNT_W'(THRESHOLD));
         // A count inside the band is not a clear majority either way.
         if ((w_fcnt[c] > CNT_W'(OVS_FACTOR - THRESHOLD)) &&
             (w_fcnt[c] < CNT_W'(THRESHOLD)))
            w_low_conf = 1'b1;
      end
   end

   assign w_push_word = {w_low_conf, w_dec_last, w_dec_dat};

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_phase    <= '0;
         r_last_cnt <= '0;
         for (int c = 0; c < DATA_W; c++) r_cnt[c] <= '0;
      end else if (i_resync || w_final) begin
         r_phase    <= '0;
         r_last_cnt <= '0;
         for (int c = 0; c < DATA_W; c++) r_cnt[c] <= '0;
      end else if (w_accept) begin
         r_phase    <= r_phase + PHASE_W'(1);
         r_last_cnt <= r_last_cnt + CNT_W'(s_axis_tlast);
         for (int c = 0; c < DATA_W; c++)
            r_cnt[c] <= r_cnt[c] + CNT_W'(s_axis_tdata[c]);
      end
   end

   axis_oversample_vote_fifo #(
      .W     (WORD_W),
      .DEPTH (OUT_DEPTH)
   ) u_out_fifo (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_push     (w_push),
      .i_push_dat (w_push_word),
      .i_pop      (w_pop),
      .o_head_dat (w_head_word),
      .o_empty    (w_fifo_empty),
      .o_full     (w_fifo_full)
   );

   assign m_axis_tvalid = !w_fifo_empty;
   assign w_pop         = m_axis_tvalid && m_axis_tready;
   assign {m_axis_tuser, m_axis_tlast, m_axis_tdata} = w_head_word;
   assign o_sym_phase   = r_phase;

endmodule

// File: tb/tb_axis_oversample_vote.sv
// Testbench for axis_oversample_vote.
// Instance A uses OVS=4, DATA_W=1, THR=3, DEPTH=2.
// Instance B uses OVS=8, DATA_W=4, THR=5, DEPTH=3.
// Checking uses a scoreboard. Per-instance expected queues are filled by a group-level vote model.
// Monitors pop from these queues on every output handshake.
module tb_axis_oversample_vote;

   localparam int A_OVS = 4, A_DW = 1, A_THR = 3, A_DEP = 2;
   localparam int B_OVS = 8, B_DW = 4, B_THR = 5, B_DEP = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic [0:0] s_dat_a = '0;
   logic       s_vld_a = 1'b0, s_last_a = 1'b0, rs_a = 1'b0, m_rdy_a = 1'b0;
   logic       s_rdy_a, m_vld_a, m_last_a, m_user_a;
   logic [0:0] m_dat_a;
   logic [1:0] phase_a;

   logic [3:0] s_dat_b = '0;
   logic       s_vld_b = 1'b0, s_last_b = 1'b0, rs_b = 1'b0, m_rdy_b = 1'b0;
   logic       s_rdy_b, m_vld_b, m_last_b, m_user_b;
   logic [3:0] m_dat_b;
   logic [2:0] phase_b;

   int n_tests = 0;
   int n_fail  = 0;

   logic [5:0] exp_a[$];
   logic [5:0] exp_b[$];
   int         grp_len[2];
   logic [3:0] grp_dat[2][16];
   logic       grp_last[2][16];

   always #5 clk = ~clk;

   axis_oversample_vote #(.OVS_FACTOR(A_OVS), .DATA_W(A_DW), .THRESHOLD(A_THR), .OUT_DEPTH(A_DEP)) u_dut_a (
      .i_clk(clk), .i_rst(rst),
      .s_axis_tdata(s_dat_a), .s_axis_tvalid(s_vld_a), .s_axis_tlast(s_last_a), .s_axis_tready(s_rdy_a),
      .m_axis_tdata(m_dat_a), .m_axis_tvalid(m_vld_a), .m_axis_tlast(m_last_a), .m_axis_tuser(m_user_a),
      .m_axis_tready(m_rdy_a), .i_resync(rs_a), .o_sym_phase(phase_a));

   axis_oversample_vote #(.OVS_FACTOR(B_OVS), .DATA_W(B_DW), .THRESHOLD(B_THR), .OUT_DEPTH(B_DEP)) u_dut_b (
      .i_clk(clk), .i_rst(rst),
      .s_axis_tdata(s_dat_b), .s_axis_tvalid(s_vld_b), .s_axis_tlast(s_last_b), .s_axis_tready(s_rdy_b),
      .m_axis_tdata(m_dat_b), .m_axis_tvalid(m_vld_b), .m_axis_tlast(m_last_b), .m_axis_tuser(m_user_b),
      .m_axis_tready(m_rdy_b), .i_resync(rs_b), .o_sym_phase(phase_b));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Group-level reference model. Beats collect into a group; a full group is voted by counting ones.
   task automatic model_accept(input int d, input logic [3:0] dat, input logic last, input logic rs);
      int ovs, thr, dw, ones, lones;
      logic [5:0] w;
      ovs = (d == 0) ? A_OVS : B_OVS;
      thr = (d == 0) ? A_THR : B_THR;
      dw  = (d == 0) ? A_DW  : B_DW;
      if (rs) begin
         grp_len[d] = 0;
         return;
      end
      grp_dat[d][grp_len[d]]  = dat;
      grp_last[d][grp_len[d]] = last;
      grp_len[d]++;
      if (grp_len[d] == ovs) begin
         w = '0;
         lones = 0;
         for (int i = 0; i < ovs; i++) lones += int'(grp_last[d][i]);
         w[4] = (lones >= thr);
         for (int c = 0; c < dw; c++) begin
            ones = 0;
            for (int i = 0; i < ovs; i++) ones += int'(grp_dat[d][i][c]);
            w[c] = (ones >= thr);
            if (ones > ovs - thr && ones < thr) w[5] = 1'b1;
         end
         if (d == 0) exp_a.push_back(w);
         else        exp_b.push_back(w);
         grp_len[d] = 0;
      end
   endtask

   task automatic drive(input int d, input logic v, input logic [3:0] dat, input logic last, input logic rs);
      if (d == 0) begin
         s_vld_a = v; s_dat_a = dat[0]; s_last_a = last; rs_a = rs;
      end else begin
         s_vld_b = v; s_dat_b = dat;    s_last_b = last; rs_b = rs;
      end
   endtask

   function automatic logic get_rdy(input int d);
      return (d == 0) ? s_rdy_a : s_rdy_b;
   endfunction

   function automatic int get_phase(input int d);
      return (d == 0) ? int'(phase_a) : int'(phase_b);
   endfunction

   function automatic int qsize(input int d);
      return (d == 0) ? exp_a.size() : exp_b.size();
   endfunction

   task automatic set_mrdy(input int d, input logic v);
      if (d == 0) m_rdy_a = v;
      else        m_rdy_b = v;
   endtask

   // Called just after a rising edge. It returns just after the edge that accepts the beat.
   task automatic send_beat(input int d, input logic [3:0] dat, input logic last, input logic rs);
      logic r;
      int   cyc;
      logic ok;
      drive(d, 1'b1, dat, last, rs);
      cyc = 0;
      ok  = 1'b0;
      while (!ok && cyc < 300) begin
         @(negedge clk);
         r = get_rdy(d);
         @(posedge clk);
         if (r) ok = 1'b1;
         else   cyc++;
      end
      if (ok) model_accept(d, dat, last, rs);
      check("beat_accepted", 32'(ok), 32'd1);
      #1;
      drive(d, 1'b0, 4'd0, 1'b0, 1'b0);
   endtask

   task automatic send_group_a(input logic [3:0] bits, input logic [3:0] lasts);
      for (int i = 0; i < A_OVS; i++) send_beat(0, {3'b000, bits[i]}, lasts[i], 1'b0);
   endtask

   task automatic pulse_resync(input int d);
      drive(d, 1'b0, 4'd0, 1'b0, 1'b1);
      @(posedge clk);
      grp_len[d] = 0;
      #1;
      drive(d, 1'b0, 4'd0, 1'b0, 1'b0);
   endtask

   task automatic drain(input int d);
      int cyc;
      set_mrdy(d, 1'b1);
      cyc = 0;
      while (qsize(d) != 0 && cyc < 200) begin
         @(posedge clk);
         cyc++;
      end
      @(posedge clk);
      #1;
      check("drain_queue_empty", 32'(qsize(d)), 32'd0);
      check("drain_no_valid", 32'((d == 0) ? m_vld_a : m_vld_b), 32'd0);
   endtask

   task automatic rand_stream(input int d, input int nbeats);
      logic done;
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < nbeats; i++) begin
               repeat ($urandom_range(0, 2)) @(posedge clk);
               #1;
               send_beat(d, 4'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
               check("rand_phase", 32'(get_phase(d)), 32'(grp_len[d]));
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1;
               set_mrdy(d, ($urandom_range(0, 3) != 0));
            end
         end
      join
      drain(d);
   endtask

   // Monitors: compare the FIFO head on every valid cycle and pop on handshake.
   // When the FIFO is empty, the outputs must read zero.
   always @(negedge clk) begin
      if (!rst) begin
         if (m_vld_a) begin
            if (exp_a.size() == 0) check("a_unexpected_output", 32'd1, 32'd0);
            else begin
               check("a_out_word", 32'({m_user_a, m_last_a, 3'b000, m_dat_a}), 32'(exp_a[0]));
               if (m_rdy_a) void'(exp_a.pop_front());
            end
         end else check("a_idle_zero", 32'({m_user_a, m_last_a, m_dat_a}), 32'd0);
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (m_vld_b) begin
            if (exp_b.size() == 0) check("b_unexpected_output", 32'd1, 32'd0);
            else begin
               check("b_out_word", 32'({m_user_b, m_last_b, m_dat_b}), 32'(exp_b[0]));
               if (m_rdy_b) void'(exp_b.pop_front());
            end
         end else check("b_idle_zero", 32'({m_user_b, m_last_b, m_dat_b}), 32'd0);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      grp_len[0] = 0;
      grp_len[1] = 0;
      // Check the reset state.
      #12;
      check("rst_s_tready", 32'(s_rdy_a), 32'd0);
      check("rst_m_valid", 32'({m_vld_a, m_vld_b}), 32'd0);
      check("rst_m_outputs", 32'({m_dat_a, m_last_a, m_user_a, m_dat_b, m_last_b, m_user_b}), 32'd0);
      check("rst_phase", 32'({phase_a, phase_b}), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("s_tready_after_rst", 32'(s_rdy_a), 32'd1);

      // Basic voting, with latency measured against an empty FIFO.
      m_rdy_a = 1'b1;
      send_beat(0, 4'd1, 1'b0, 1'b0);
      send_beat(0, 4'd1, 1'b0, 1'b0);
      send_beat(0, 4'd0, 1'b0, 1'b0);
      check("a_latency_pre", 32'(m_vld_a), 32'd0);
      send_beat(0, 4'd1, 1'b0, 1'b0);
      check("a_latency_valid", 32'(m_vld_a), 32'd1);
      send_group_a(4'b0100, 4'b0000);                 // chips 0,0,1,0
      send_group_a(4'b0101, 4'b0000);                 // chips 1,0,1,0: ambiguous
      send_group_a(4'b1111, 4'b0111);                 // tlast on 3 of 4 beats
      send_group_a(4'b0000, 4'b0011);                 // tlast on 2 of 4 beats
      drain(0);

      // Backpressure: two groups fill the depth-2 FIFO, and a third group stalls.
      @(posedge clk);
      #1;
      m_rdy_a = 1'b0;
      send_group_a(4'b1111, 4'b0000);
      check("bp_tready_one_word", 32'(s_rdy_a), 32'd1);
      send_group_a(4'b0000, 4'b1111);
      check("bp_tready_full", 32'(s_rdy_a), 32'd0);
      fork
         send_group_a(4'b1011, 4'b0000);
         begin
            repeat (3) @(posedge clk);
            #1;
            check("bp_tready_still_low", 32'(s_rdy_a), 32'd0);
            m_rdy_a = 1'b1;
            @(negedge clk);
            check("bp_tready_before_pop", 32'(s_rdy_a), 32'd0);
            @(posedge clk);
            #1;
            check("bp_tready_after_pop", 32'(s_rdy_a), 32'd1);
         end
      join
      drain(0);

      // Resync after two beats, followed by a clean group of ones.
      @(posedge clk);
      #1;
      send_beat(0, 4'd1, 1'b1, 1'b0);
      send_beat(0, 4'd0, 1'b0, 1'b0);
      check("phase_before_resync", 32'(phase_a), 32'd2);
      pulse_resync(0);
      check("phase_after_resync", 32'(phase_a), 32'd0);
      send_group_a(4'b1111, 4'b0000);
      drain(0);

      // A resync that arrives with the final sample swallows the whole symbol.
      @(posedge clk);
      #1;
      send_beat(0, 4'd1, 1'b0, 1'b0);
      send_beat(0, 4'd1, 1'b0, 1'b0);
      send_beat(0, 4'd1, 1'b0, 1'b0);
      send_beat(0, 4'd1, 1'b0, 1'b1);
      check("resync_final_no_push", 32'(m_vld_a), 32'd0);
      check("resync_final_phase", 32'(phase_a), 32'd0);
      drain(0);

      rand_stream(0, 200);

      // Asynchronous reset in the middle of a group while the FIFO holds a word.
      @(posedge clk);
      #1;
      m_rdy_a = 1'b0;
      send_group_a(4'b1111, 4'b0000);
      send_beat(0, 4'd1, 1'b0, 1'b0);
      send_beat(0, 4'd1, 1'b0, 1'b0);
      #3;
      rst = 1'b1;
      exp_a.delete();
      grp_len[0] = 0;
      #1;
      check("arst_valid", 32'(m_vld_a), 32'd0);
      check("arst_outputs", 32'({m_dat_a, m_last_a, m_user_a}), 32'd0);
      check("arst_tready", 32'(s_rdy_a), 32'd0);
      check("arst_phase", 32'(phase_a), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      m_rdy_a = 1'b1;
      send_group_a(4'b1111, 4'b0000);
      drain(0);

      // Instance B: per-channel counts 8,5,4,3 should decide 0011 and flag low confidence.
      @(posedge clk);
      #1;
      m_rdy_b = 1'b1;
      for (int i = 0; i < B_OVS; i++) begin
         logic [3:0] v;
         v[0] = 1'b1;
         v[1] = (i < 5);
         v[2] = (i < 4);
         v[3] = (i < 3);
         send_beat(1, v, (i < 5), 1'b0);
      end
      check("b_latency_valid", 32'(m_vld_b), 32'd1);
      check("b_decided_word", 32'({m_user_b, m_last_b, m_dat_b}), 32'b1_1_0011);
      drain(1);
      rand_stream(1, 240);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
